// File: rtl/grostl_pkg.sv
// grostl_pkg: shared constants, FSM state type and inverse affine helper for the inverse S-box
package grostl_pkg;
   localparam logic [8:0] GF_POLY      = 9'h11B;
   localparam logic [7:0] INV_AFFINE_C = 8'h05;
   localparam logic [7:0] INV_EXP      = 8'hFE;
   typedef enum logic [1:0] {IDLE, CALC, DONE} inv_sbox_state_t;
   function automatic logic [7:0] inv_affine(input logic [7:0] y);
      return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ INV_AFFINE_C;
   endfunction
endpackage

// File: rtl/grostl_gf256_mul.sv
// grostl_gf256_mul: combinational GF(2^8) multiplier, reduction polynomial 0x11B
module grostl_gf256_mul
   import grostl_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] p
);
   logic [7:0] acc, sh;
   always_comb begin
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         acc = acc ^ (b[i] ? sh : 8'h00);
         sh  = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
      end
      p = acc;
   end
endmodule

// File: rtl/grostl_inv_sbox_seq.sv
// grostl_inv_sbox_seq: multi-cycle inverse S-box, inverse affine then x^254 by square-and-multiply
module grostl_inv_sbox_seq
   import grostl_pkg::*;
#(
   parameter int STEPS_PER_CYCLE = 1
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data
);
   localparam int S = STEPS_PER_CYCLE;
   if (!(S == 1 || S == 2 || S == 4 || S == 8)) begin : g_bad_steps
      $error("STEPS_PER_CYCLE must be 1, 2, 4 or 8");
   end
   inv_sbox_state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] a, r;
   logic [7:0] rc [0:S];
   assign rc[0] = r;
   // exponent is scanned MSB first; step k of this cycle handles bit 7-(cnt+k)
   for (genvar k = 0; k < S; k++) begin : g_step
      logic [2:0] pos;
      logic [7:0] sq, pm;
      assign pos = 3'd7 - cnt[2:0] - 3'(k);
      grostl_gf256_mul u_sq  (.a(rc[k]), .b(rc[k]), .p(sq));
      grostl_gf256_mul u_mul (.a(sq),    .b(a),     .p(pm));
      assign rc[k+1] = INV_EXP[pos] ? pm : sq;
   end
   assign cnt_nxt = (cnt >= 4'd8 - 4'(S)) ? 4'd8 : cnt + 4'(S);
   always_ff @(posedge clk) begin
      state <= reset ? IDLE : state_nxt;
   end
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = in_valid ? CALC : IDLE;
         CALC:    state_nxt = (cnt_nxt == 4'd8) ? DONE : CALC;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == DONE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         a        <= 8'h00;
         r        <= 8'h01;
         cnt      <= 4'd0;
         out_data <= 8'h00;
      end else if (state == IDLE && in_valid) begin
         a   <= inv_affine(in_data);
         r   <= 8'h01;
         cnt <= 4'd0;
      end else if (state == CALC) begin
         r   <= rc[S];
         cnt <= cnt_nxt;
         if (cnt_nxt == 4'd8) out_data <= rc[S];
      end
   end
endmodule

// File: tb/tb_grostl_inv_sbox_seq.sv
// tb_grostl_inv_sbox_seq: directed vectors against a table model built from the forward S-box
module tb_grostl_inv_sbox_seq;
   parameter int SPC = 1;
   localparam int N = 8 / SPC;
   logic       clk, reset, in_valid, in_ready, out_valid, out_ready;
   logic [7:0] in_data, out_data;
   int         n_vec, n_fail, cyc;
   logic [7:0] fwd_t [256];
   logic [7:0] inv_t [256];
   int         m_cnt;
   logic [7:0] m_exp, m_out;
   bit         m_on;

   grostl_inv_sbox_seq #(.STEPS_PER_CYCLE(SPC)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   initial clk = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      int p = 0;
      for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (int'(x) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11B << (i - 8));
      return p[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
      return 8'(({v, v} << n) >> 8);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) b = 8'(c);
      return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // cycle-count model: 0 idle, 1..N computing, N+1 result held
   always @(posedge clk) begin
      if (reset) begin
         m_cnt = 0;
         m_out = 8'h00;
         m_on  = 1;
      end else if (m_cnt == 0) begin
         if (in_valid) begin
            m_cnt = 1;
            m_exp = inv_t[in_data];
         end
      end else if (m_cnt <= N) begin
         m_cnt++;
         if (m_cnt == N + 1) m_out = m_exp;
      end else if (out_ready) m_cnt = 0;
   end

   always @(negedge clk) if (m_on) begin
      chk("mon_in_ready", {7'd0, in_ready}, {7'd0, m_cnt == 0});
      chk("mon_out_valid", {7'd0, out_valid}, {7'd0, m_cnt == N + 1});
      chk("mon_out_data", out_data, m_out);
   end

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic xfer(input logic [7:0] y, input logic [7:0] x);
      int lat;
      chk("pre_in_ready", {7'd0, in_ready}, 8'd1);
      in_valid = 1;
      in_data  = y;
      @(posedge clk); #1;
      in_valid = 0;
      wait_out(lat);
      chk("latency", 8'(lat), 8'(N + 1));
      chk("result", out_data, x);
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("ready_after_take", {7'd0, in_ready}, 8'd1);
   endtask

   initial begin
      int lat, acc_n;
      int acc_t [3];
      logic [7:0] sb [3];
      n_vec = 0; n_fail = 0; cyc = 0; m_on = 0; m_cnt = 0;
      reset = 1; in_valid = 0; in_data = 8'h00; out_ready = 0;
      for (int x = 0; x < 256; x++) begin
         fwd_t[x] = sbox(8'(x));
         inv_t[fwd_t[x]] = 8'(x);
      end
      chk("model_s00", fwd_t[8'h00], 8'h63);
      chk("model_s01", fwd_t[8'h01], 8'h7C);
      chk("model_sff", fwd_t[8'hFF], 8'h16);
      chk("model_s52", fwd_t[8'h52], 8'h00);
      chk("model_s53", fwd_t[8'h53], 8'hED);
      repeat (2) @(posedge clk);
      #1 reset = 0;
      chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
      chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
      chk("rst_out_data", out_data, 8'h00);

      xfer(8'h63, 8'h00);
      xfer(8'h7C, 8'h01);
      xfer(8'h16, 8'hFF);
      xfer(8'h00, 8'h52);
      for (int x = 0; x < 256; x++) xfer(fwd_t[x], 8'(x));

      // back-pressure with a rejected offer while busy
      in_valid = 1; in_data = 8'hED;
      @(posedge clk); #1;
      in_valid = 0;
      wait_out(lat);
      for (int i = 0; i < 20; i++) begin
         chk("bp_out_valid", {7'd0, out_valid}, 8'd1);
         chk("bp_out_data", out_data, 8'h53);
         chk("bp_in_ready", {7'd0, in_ready}, 8'd0);
         in_valid = 1; in_data = 8'h11;
         @(posedge clk); #1;
      end
      in_valid = 0;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp_release_ready", {7'd0, in_ready}, 8'd1);
      chk("bp_release_valid", {7'd0, out_valid}, 8'd0);

      // back-to-back streaming
      sb[0] = fwd_t[8'h10]; sb[1] = fwd_t[8'h20]; sb[2] = fwd_t[8'hAB];
      in_valid = 1; in_data = sb[0]; out_ready = 1; acc_n = 0;
      for (int i = 0; i < 80 && acc_n < 3; i++) begin
         if (in_ready) begin
            acc_t[acc_n] = cyc;
            acc_n++;
         end
         @(posedge clk); #1;
         if (acc_n < 3) in_data = sb[acc_n];
         else in_valid = 0;
      end
      in_valid = 0;
      chk("stream_accepts", 8'(acc_n), 8'd3);
      if (acc_n == 3) begin
         chk("stream_gap1", 8'(acc_t[1] - acc_t[0]), 8'(N + 2));
         chk("stream_gap2", 8'(acc_t[2] - acc_t[1]), 8'(N + 2));
      end
      repeat (N + 3) @(posedge clk);
      #1 out_ready = 0;
      chk("stream_idle", {7'd0, in_ready}, 8'd1);

      // reset in the middle of a computation
      in_valid = 1; in_data = 8'h16;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1;
      @(posedge clk); #1;
      reset = 0;
      chk("mid_rst_valid", {7'd0, out_valid}, 8'd0);
      chk("mid_rst_ready", {7'd0, in_ready}, 8'd1);
      chk("mid_rst_data", out_data, 8'h00);
      xfer(fwd_t[8'hC3], 8'hC3);

      // reset wins over a simultaneous in_valid
      reset = 1; in_valid = 1; in_data = 8'h7C;
      @(posedge clk); #1;
      reset = 0; in_valid = 0;
      chk("rst_iv_ready", {7'd0, in_ready}, 8'd1);
      repeat (N + 2) @(posedge clk);
      #1;
      chk("rst_iv_no_out", {7'd0, out_valid}, 8'd0);
      chk("rst_iv_idle", {7'd0, in_ready}, 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
